cpu_bus_mem: RTL and testbench

- Memory-side responder for the Cpu read/write request interface (req_rdwr, which_rdwr, addr, data_out/data_in).
- Services single-byte reads and writes to an internal RAM window.
- Drives the Cpu's enable input low to stall it until the access completes, with a parameterised number of wait states.
- Sits between Cpu and test bench or top level; replaces ad-hoc bench memory models.

---
 rtl/cpu_bus_mem_if.sv | 30 +++
 rtl/cpu_bus_mem.sv | 110 +++++++++++
 tb/tb_cpu_bus_mem.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_mem_if
// Brief    : Cpu read/write request bus between the Cpu and the memory responder.
// Revision : 1.0
// ============================================================================
interface cpu_bus_mem_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
);
   logic                  req_rdwr;
   logic                  which_rdwr;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  cpu_enable;
   logic                  ack;
   logic                  bus_err;

   modport master (
      output req_rdwr, which_rdwr, addr, wr_data,
      input  rd_data, cpu_enable, ack, bus_err
   );

   modport slave (
      input  req_rdwr, which_rdwr, addr, wr_data,
      output rd_data, cpu_enable, ack, bus_err
   );
endinterface
`default_nettype wire

// File: rtl/cpu_bus_mem.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_mem
// Brief    : Byte RAM window responder for the Cpu bus; stalls the Cpu per access.
// Revision : 1.0
// ============================================================================
module cpu_bus_mem #(
   parameter int                    ADDR_WIDTH  = 16,
   parameter int                    DATA_WIDTH  = 8,
   parameter logic [ADDR_WIDTH-1:0] WIN_BASE    = 16'hF000,
   parameter int                    WIN_LOG2    = 12,
   parameter int                    WAIT_STATES = 0
) (
   input  wire logic     clk,
   input  wire logic     rst,
   cpu_bus_mem_if.slave  bus
);
   localparam int             C_DEPTH    = 1 << WIN_LOG2;
   localparam logic [3:0]     C_WAIT_CNT = WAIT_STATES[3:0];

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [3:0]            r_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_we;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_ram [C_DEPTH];

   logic [ADDR_WIDTH-1:0] w_off;
   logic [WIN_LOG2-1:0]   w_idx;
   logic                  w_in_win;
   logic                  w_accept;
   logic                  w_fire;

   // Unsigned wrap makes addresses below the base land far outside the window.
   assign w_off    = r_addr - WIN_BASE;
   assign w_idx    = w_off[WIN_LOG2-1:0];
   assign w_in_win = (w_off >> WIN_LOG2) == '0;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_fire   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.req_rdwr) begin
               w_accept = 1'b1;
               w_next   = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (r_cnt == 4'd0) begin
               w_fire = 1'b1;
               w_next = S_DONE;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_we      <= 1'b0;
         r_rd_data <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr  <= bus.addr;
            r_wdata <= bus.wr_data;
            r_we    <= bus.which_rdwr;
            r_cnt   <= C_WAIT_CNT;
            r_err   <= 1'b0;
         end else if (r_state == S_ACCESS && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_fire) begin
            r_err <= !w_in_win;
            if (!r_we) r_rd_data <= w_in_win ? r_ram[w_idx] : '1;
         end
      end
   end

   // RAM is never cleared; a reset on the commit edge suppresses the write.
   always_ff @(posedge clk) begin
      if (!rst && w_fire && r_we && w_in_win) r_ram[w_idx] <= r_wdata;
   end

   assign bus.rd_data    = r_rd_data;
   assign bus.ack        = (r_state == S_DONE);
   assign bus.bus_err    = (r_state == S_DONE) && r_err;
   assign bus.cpu_enable = !(bus.req_rdwr && r_state != S_DONE);
endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_bus_mem
// Brief    : Self-checking bench for cpu_bus_mem with zero and three wait states.
// Revision : 1.0
// ============================================================================
module tb_cpu_bus_mem;
   logic clk;
   logic rst0;
   logic rst3;
   int   checks;
   int   errors;
   int   cyc;

   cpu_bus_mem_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus0 ();
   cpu_bus_mem_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus3 ();

   cpu_bus_mem #(.WAIT_STATES(0)) u_dut0 (.clk(clk), .rst(rst0), .bus(bus0));
   cpu_bus_mem #(.WAIT_STATES(3)) u_dut3 (.clk(clk), .rst(rst3), .bus(bus3));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          we;
      logic [15:0] addr;
      logic [7:0]  wd;
      logic [7:0]  exp_rd;
      bit          exp_err;
   } vec_t;

   vec_t        tbl [10];
   logic [7:0]  mem_m   [2][4096];
   bit          known_m [2][4096];
   logic [7:0]  prev_rd [2];
   bit          prev_ok [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input int sel, input logic req, input logic we,
                        input logic [15:0] a, input logic [7:0] d);
      if (sel == 0) begin
         bus0.req_rdwr = req; bus0.which_rdwr = we; bus0.addr = a; bus0.wr_data = d;
      end else begin
         bus3.req_rdwr = req; bus3.which_rdwr = we; bus3.addr = a; bus3.wr_data = d;
      end
   endtask

   task automatic peek(input int sel, output logic en, output logic ak,
                       output logic er, output logic [7:0] rd);
      if (sel == 0) begin
         en = bus0.cpu_enable; ak = bus0.ack; er = bus0.bus_err; rd = bus0.rd_data;
      end else begin
         en = bus3.cpu_enable; ak = bus3.ack; er = bus3.bus_err; rd = bus3.rd_data;
      end
   endtask

   // Called just after a falling edge; returns after the falling edge following DONE.
   task automatic access(input int sel, input logic we, input logic [15:0] a,
                         input logic [7:0] d, input bit hold, output int stall,
                         output logic [7:0] rd, output logic err, output bit got,
                         output int ack_cyc);
      logic en, ak, er;
      logic [7:0] r;
      stall = 0; rd = '0; err = 1'b0; got = 1'b0; ack_cyc = 0;
      drive(sel, 1'b1, we, a, d);
      for (int k = 0; k < 40 && !got; k++) begin
         #1;
         peek(sel, en, ak, er, r);
         if (ak) begin
            got = 1'b1; rd = r; err = er; ack_cyc = cyc;
            if (!en) stall += 100;
         end else if (!en) begin
            stall++;
         end
         @(negedge clk);
      end
      if (!hold) drive(sel, 1'b0, 1'b0, a, d);
   endtask

   function automatic bit in_win(input logic [15:0] a);
      int ai;
      ai = int'(a);
      return (ai >= 'hF000) && (ai < 'hF000 + 4096);
   endfunction

   initial begin
      int         st, ac, exp_st, nacks;
      int         acs [4];
      logic [7:0] rd, exp_rd;
      logic       er, en, ak;
      bit         got, we, sel_known;
      logic [15:0] a;
      logic [7:0]  d;
      int          sel;

      checks = 0; errors = 0; cyc = 0;
      tbl[0] = '{1'b1, 16'hF000, 8'h45, 8'h00, 1'b0};
      tbl[1] = '{1'b0, 16'hF000, 8'h00, 8'h45, 1'b0};
      tbl[2] = '{1'b1, 16'hF500, 8'h87, 8'h45, 1'b0};
      tbl[3] = '{1'b0, 16'hF500, 8'h00, 8'h87, 1'b0};
      tbl[4] = '{1'b0, 16'h2329, 8'h00, 8'hFF, 1'b1};
      tbl[5] = '{1'b1, 16'h0000, 8'h12, 8'hFF, 1'b1};
      tbl[6] = '{1'b0, 16'hF000, 8'h00, 8'h45, 1'b0};
      tbl[7] = '{1'b0, 16'hEFFF, 8'h00, 8'hFF, 1'b1};
      tbl[8] = '{1'b1, 16'hFFFF, 8'h3C, 8'hFF, 1'b0};
      tbl[9] = '{1'b0, 16'hFFFF, 8'h00, 8'h3C, 1'b0};

      rst0 = 1'b1; rst3 = 1'b1;
      drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
      drive(3, 1'b0, 1'b0, 16'h0, 8'h0);
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         peek(s == 0 ? 0 : 3, en, ak, er, rd);
         chk($sformatf("reset_rd[%0d]", s), rd, 8'h00);
         chk($sformatf("reset_ack[%0d]", s), ak, 1'b0);
         chk($sformatf("reset_err[%0d]", s), er, 1'b0);
         chk($sformatf("reset_en[%0d]", s), en, 1'b1);
      end
      rst0 = 1'b0; rst3 = 1'b0;
      @(negedge clk);

      // Directed table on the zero-wait-state instance
      for (int i = 0; i < 10; i++) begin
         access(0, tbl[i].we, tbl[i].addr, tbl[i].wd, 1'b0, st, rd, er, got, ac);
         chk($sformatf("tbl%0d_ack", i), got, 1'b1);
         chk($sformatf("tbl%0d_stall", i), st, 2);
         chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
         chk($sformatf("tbl%0d_err", i), er, tbl[i].exp_err);
         @(negedge clk);
      end

      // Back-to-back: store 45/87, load both with req held high throughout
      access(0, 1'b1, 16'hF000, 8'h45, 1'b1, st, rd, er, got, acs[0]);
      access(0, 1'b1, 16'hF500, 8'h87, 1'b1, st, rd, er, got, acs[1]);
      access(0, 1'b0, 16'hF000, 8'h00, 1'b1, st, rd, er, got, acs[2]);
      chk("b2b_regB", rd, 8'h45);
      access(0, 1'b0, 16'hF500, 8'h00, 1'b0, st, rd, er, got, acs[3]);
      chk("b2b_regA", rd, 8'h87);
      chk("b2b_ack3", got, 1'b1);
      for (int i = 1; i < 4; i++) chk($sformatf("b2b_gap%0d", i), acs[i] - acs[i-1], 3);

      // Three wait states: five stalled cycles
      access(3, 1'b1, 16'hF500, 8'h87, 1'b0, st, rd, er, got, ac);
      access(3, 1'b0, 16'hF500, 8'h00, 1'b0, st, rd, er, got, ac);
      chk("ws3_ack", got, 1'b1);
      chk("ws3_stall", st, 5);
      chk("ws3_rd", rd, 8'h87);

      // Inputs changed during ACCESS are ignored
      access(3, 1'b1, 16'hF000, 8'h11, 1'b0, st, rd, er, got, ac);
      drive(3, 1'b1, 1'b0, 16'hF000, 8'h00);
      @(negedge clk);
      drive(3, 1'b1, 1'b1, 16'hF500, 8'hEE);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         #1; peek(3, en, ak, er, rd);
         if (ak) got = 1'b1;
         else @(negedge clk);
      end
      chk("held_ack", got, 1'b1);
      chk("held_rd", rd, 8'h11);
      chk("held_err", er, 1'b0);
      @(negedge clk);
      drive(3, 1'b0, 1'b0, 16'h0, 8'h0);
      @(negedge clk);
      access(3, 1'b0, 16'hF500, 8'h00, 1'b0, st, rd, er, got, ac);
      chk("held_nowrite", rd, 8'h87);

      // Reset in the middle of a write abandons it
      access(3, 1'b1, 16'hF010, 8'h55, 1'b0, st, rd, er, got, ac);
      drive(3, 1'b1, 1'b1, 16'hF010, 8'hAA);
      repeat (2) @(negedge clk);
      rst3 = 1'b1;
      drive(3, 1'b0, 1'b0, 16'h0, 8'h0);
      @(negedge clk);
      peek(3, en, ak, er, rd);
      chk("rst_ack", ak, 1'b0);
      chk("rst_err", er, 1'b0);
      chk("rst_rd", rd, 8'h00);
      rst3 = 1'b0;
      nacks = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); peek(3, en, ak, er, rd);
         if (ak || er) nacks++;
      end
      chk("rst_idle", nacks, 0);
      access(3, 1'b0, 16'hF010, 8'h00, 1'b0, st, rd, er, got, ac);
      chk("rst_nocommit", rd, 8'h55);

      // Randomised traffic against an address-map model
      for (int s = 0; s < 2; s++) begin
         prev_ok[s] = 1'b0;
         for (int j = 0; j < 4096; j++) known_m[s][j] = 1'b0;
      end
      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 1);
         we  = 1'($urandom_range(0, 1));
         d   = 8'($urandom);
         if ($urandom_range(0, 3) != 0) a = 16'hF000 + 16'($urandom_range(0, 31));
         else begin
            a = 16'($urandom);
            if (in_win(a)) a = a & 16'hEFFF;
         end
         sel_known = 1'b1;
         if (in_win(a)) begin
            if (we) begin
               mem_m[sel][int'(a) - 'hF000] = d;
               known_m[sel][int'(a) - 'hF000] = 1'b1;
               exp_rd = prev_rd[sel]; sel_known = prev_ok[sel];
            end else begin
               exp_rd = mem_m[sel][int'(a) - 'hF000];
               sel_known = known_m[sel][int'(a) - 'hF000];
            end
         end else begin
            exp_rd = we ? prev_rd[sel] : 8'hFF;
            sel_known = we ? prev_ok[sel] : 1'b1;
         end
         exp_st = (sel == 0) ? 2 : 5;
         access(sel == 0 ? 0 : 3, we, a, d, 1'b0, st, rd, er, got, ac);
         chk($sformatf("rnd%0d_ack", n), got, 1'b1);
         chk($sformatf("rnd%0d_stall", n), st, exp_st);
         chk($sformatf("rnd%0d_err", n), er, !in_win(a));
         if (sel_known) chk($sformatf("rnd%0d_rd a=%0h", n, a), rd, exp_rd);
         prev_rd[sel] = sel_known ? exp_rd : rd;
         prev_ok[sel] = sel_known;
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
